spi_arbiter: RTL and testbench

Shares one spi_master between NUM_REQ requesters. Each requester has its own slave-select line and stored SCLK divider and mode. The block arbitrates round-robin, loads the winner's configuration and transmit byte into the master, then pulses the master's latch. It tracks the master's idle flag to completion and returns the received byte, or a timeout, to the winner. It sits between the system-side clients and spi_master / spi_intf.

---
 rtl/spi_arbiter.sv | 119 +++++++++++
 tb/tb_spi_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin share of one spi_master; clients req/gnt/rsp_*, per-client cfg_*, master m_*, slave selects cs_n
module spi_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int CLK_CNT_WIDTH = 16,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_timeout,
  output logic                          busy,
  input  logic                          cfg_we,
  input  logic [$clog2(NUM_REQ)-1:0]    cfg_idx,
  input  logic [CLK_CNT_WIDTH-1:0]      cfg_sclk_div,
  input  logic [1:0]                    cfg_mode,
  input  logic [TIMEOUT_WIDTH-1:0]      timeout_limit,
  output logic                          m_latch,
  output logic [DATA_WIDTH-1:0]         m_data_in,
  output logic [CLK_CNT_WIDTH-1:0]      m_sclk_div,
  output logic [1:0]                    m_mode,
  input  logic                          m_idle,
  input  logic [DATA_WIDTH-1:0]         m_data_out,
  input  logic                          m_cs,
  output logic [NUM_REQ-1:0]            cs_n
);
  localparam int IW = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);
  typedef enum logic [2:0] {DRAIN, IDLE, SETUP, LATCH, WAIT_START, WAIT_DONE, RESP} state_t;
  state_t state, state_nx;
  logic idle_m, idle_s, to_q, adv, tmo, any;
  logic [IW-1:0] sel, ptr, win, idx;
  logic [NUM_REQ-1:0] sel_oh;
  logic [TIMEOUT_WIDTH-1:0] cnt;
  logic [CLK_CNT_WIDTH-1:0] div_q [NUM_REQ];
  logic [1:0] mode_q [NUM_REQ];

  always_comb begin
    win = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IW'((int'(ptr) + k) % NUM_REQ);
      if (!any && req[idx]) begin
        win = idx;
        any = 1'b1;
      end
    end
  end

  always_comb begin
    adv = (state == WAIT_START && !idle_s) || (state == WAIT_DONE && idle_s);
    tmo = (state == WAIT_START || state == WAIT_DONE) && !adv && timeout_limit != '0 && cnt == timeout_limit;
    state_nx = state;
    case (state)
      DRAIN:      state_nx = idle_s ? IDLE : DRAIN;
      IDLE:       state_nx = any ? SETUP : IDLE;
      SETUP:      state_nx = LATCH;
      LATCH:      state_nx = WAIT_START;
      WAIT_START: state_nx = adv ? WAIT_DONE : tmo ? RESP : WAIT_START;
      WAIT_DONE:  state_nx = (adv || tmo) ? RESP : WAIT_DONE;
      default:    state_nx = to_q ? DRAIN : IDLE;
    endcase
  end

  assign sel_oh      = ONE << sel;
  assign gnt         = state == SETUP ? sel_oh : '0;
  assign rsp_valid   = state == RESP ? sel_oh : '0;
  assign rsp_timeout = state == RESP && to_q;
  assign busy        = state != IDLE;
  assign m_latch     = state == LATCH;
  assign cs_n        = (state == LATCH || state == WAIT_START || state == WAIT_DONE) ? ~sel_oh | {NUM_REQ{m_cs}} : '1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= DRAIN;
      idle_m     <= 1'b0;
      idle_s     <= 1'b0;
      to_q       <= 1'b0;
      sel        <= '0;
      ptr        <= '0;
      cnt        <= '0;
      rsp_data   <= '0;
      m_data_in  <= '0;
      m_sclk_div <= CLK_CNT_WIDTH'(2);
      m_mode     <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        div_q[i]  <= CLK_CNT_WIDTH'(2);
        mode_q[i] <= '0;
      end
    end else begin
      state  <= state_nx;
      idle_m <= m_idle;
      idle_s <= idle_m;
      cnt    <= state_nx != state ? '0 : cnt + 1'b1;
      if (cfg_we) begin
        div_q[cfg_idx]  <= cfg_sclk_div;
        mode_q[cfg_idx] <= cfg_mode;
      end
      if (state == IDLE) sel <= win;
      if (state == SETUP) begin
        m_data_in  <= req_data[sel*DATA_WIDTH +: DATA_WIDTH];
        m_sclk_div <= div_q[sel];
        m_mode     <= mode_q[sel];
        ptr        <= sel == IW'(NUM_REQ-1) ? '0 : sel + 1'b1;
        to_q       <= 1'b0;
      end
      if (state == WAIT_DONE && idle_s) rsp_data <= m_data_out;
      if (tmo) begin
        rsp_data <= '0;
        to_q     <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: randomized self-checking bench for spi_arbiter with a transaction-level reference model
module tb_spi_arbiter;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic [3:0] req = 0;
  logic [31:0] req_data = 0;
  logic [3:0] gnt, rsp_valid, cs_n;
  logic [7:0] rsp_data, m_data_in;
  logic rsp_timeout, busy, m_latch;
  logic cfg_we = 0;
  logic [1:0] cfg_idx = 0, cfg_mode = 0, m_mode;
  logic [15:0] cfg_sclk_div = 0, timeout_limit = 0, m_sclk_div;
  logic m_idle, m_cs;
  logic [7:0] m_data_out = 0;
  int total = 0, bad = 0;
  int p = 0;
  logic [3:0] rq = 0;
  logic [7:0] dat [4];
  logic [15:0] ediv [4];
  logic [1:0] emode [4];
  bit mm_en = 1, force_idle = 1;
  logic [7:0] rx_next = 0, rx_hold = 0;
  int ph = 0, cm = 0;

  spi_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_timeout(rsp_timeout), .busy(busy), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_sclk_div(cfg_sclk_div), .cfg_mode(cfg_mode), .timeout_limit(timeout_limit), .m_latch(m_latch),
    .m_data_in(m_data_in), .m_sclk_div(m_sclk_div), .m_mode(m_mode), .m_idle(m_idle),
    .m_data_out(m_data_out), .m_cs(m_cs), .cs_n(cs_n)
  );

  // spi_master stand-in: accepts a latch while idle, starts after a random delay, runs a random length
  always @(negedge clk) begin
    if (!mm_en) begin
      ph = 0;
      m_idle = force_idle;
      m_cs = force_idle;
    end else if (ph == 0) begin
      m_idle = 1;
      m_cs = 1;
      if (m_latch) begin
        rx_hold = rx_next;
        cm = $urandom_range(0, 3);
        ph = 1;
      end
    end else if (ph == 1) begin
      if (cm == 0) begin
        m_idle = 0;
        m_cs = 0;
        cm = $urandom_range(1, 6);
        ph = 2;
      end else cm--;
    end else begin
      if (cm == 0) begin
        m_data_out = rx_hold;
        m_idle = 1;
        m_cs = 1;
        ph = 0;
      end else cm--;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int exp_win(input logic [3:0] r, input int ptr);
    for (int k = 0; k < 4; k++) if (r[2'((ptr + k) % 4)]) return (ptr + k) % 4;
    return 0;
  endfunction

  task automatic set_req(input int i, input logic [7:0] d);
    rq[i] = 1'b1;
    dat[i] = d;
    req_data[i*8 +: 8] = d;
    req = rq;
  endtask

  task automatic cfg_write(input int i, input logic [15:0] dv, input logic [1:0] md);
    cfg_we = 1;
    cfg_idx = 2'(i);
    cfg_sclk_div = dv;
    cfg_mode = md;
    tick();
    cfg_we = 0;
    ediv[i] = dv;
    emode[i] = md;
  endtask

  task automatic reset_model();
    p = 0;
    for (int i = 0; i < 4; i++) begin
      ediv[i] = 16'd2;
      emode[i] = 2'd0;
    end
  endtask

  // stuck: 0 = normal master, 1 = idle never drops, 2 = idle drops and never returns
  task automatic serve(input int stuck, input bit cfg_mid, input bit extra);
    int ew, n, eg;
    bit got, seen, cs_done;
    logic [15:0] odiv;
    logic [3:0] oh, ocs;
    ew = exp_win(rq, p);
    oh = 4'b0001 << ew;
    ocs = ~oh;
    got = 0;
    for (int c = 0; c < 200 && !got; c++) begin
      tick();
      got = |gnt;
    end
    chk("gnt_seen", 32'(got), 1);
    if (!got) return;
    chk("gnt", gnt, oh);
    rq[ew] = 1'b0;
    req = rq;
    p = (ew + 1) % 4;
    tick();
    chk("latch", m_latch, 1);
    chk("m_data_in", m_data_in, dat[ew]);
    chk("m_sclk_div", m_sclk_div, ediv[ew]);
    chk("m_mode", m_mode, emode[ew]);
    odiv = ediv[ew];
    n = 0;
    eg = 0;
    if (stuck == 2) force_idle = 0;
    if (cfg_mid) begin
      cfg_write(ew, 16'($urandom_range(3, 40)), 2'($urandom));
      n++;
      chk("div_hold", m_sclk_div, odiv);
    end
    if (extra) for (int i = 0; i < 4; i++) if (!rq[i] && $urandom_range(0, 1) == 1) set_req(i, 8'($urandom));
    seen = 0;
    cs_done = 0;
    for (int c = 0; c < 300 && !seen; c++) begin
      tick();
      n++;
      if (|gnt) eg++;
      if (stuck == 0 && !cs_done && !m_cs) begin
        chk("cs_n", cs_n, ocs);
        cs_done = 1;
      end
      seen = |rsp_valid;
    end
    chk("rsp_seen", 32'(seen), 1);
    if (!seen) return;
    chk("one_inflight", eg, 0);
    chk("rsp_valid", rsp_valid, oh);
    chk("rsp_timeout", rsp_timeout, 32'(stuck != 0));
    chk("rsp_data", rsp_data, stuck != 0 ? 0 : rx_next);
    if (stuck != 0) chk("to_cycles", n, timeout_limit + (stuck == 1 ? 2 : 4));
  endtask

  initial begin
    int nb, ng, ew;
    bit got;
    logic [3:0] oh;
    reset_model();
    for (int i = 0; i < 4; i++) dat[i] = 0;
    tick();
    tick();
    chk("rst_busy", busy, 1);
    chk("rst_gnt", gnt, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_cs_n", cs_n, 4'hF);
    chk("rst_latch", m_latch, 0);
    chk("rst_div", m_sclk_div, 2);
    chk("rst_mode", m_mode, 0);
    chk("rst_data_in", m_data_in, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_to", rsp_timeout, 0);
    rst = 0;
    tick();
    chk("busy_c1", busy, 1);
    tick();
    chk("busy_c2", busy, 1);
    tick();
    chk("busy_c3", busy, 0);
    // first transfer with a programmed config
    cfg_write(1, 16'd4, 2'd3);
    set_req(1, 8'hA5);
    rx_next = 8'h3C;
    serve(0, 0, 0);
    // pointer now 2, two low requesters wrap around
    set_req(0, 8'($urandom));
    set_req(1, 8'($urandom));
    rx_next = 8'($urandom);
    serve(0, 0, 0);
    rx_next = 8'($urandom);
    serve(0, 0, 0);
    // all four requesting
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 4; i++) if (!rq[i]) set_req(i, 8'($urandom));
      rx_next = 8'($urandom);
      serve(0, 0, 0);
    end
    // cfg write during a transfer only affects the next one
    rq = 0;
    req = 0;
    set_req(2, 8'($urandom));
    rx_next = 8'($urandom);
    serve(0, 1, 0);
    set_req(2, 8'($urandom));
    rx_next = 8'($urandom);
    serve(0, 0, 0);
    // timeout while the master never leaves idle
    timeout_limit = 10;
    mm_en = 0;
    force_idle = 1;
    set_req(0, 8'($urandom));
    serve(1, 0, 0);
    // timeout while the master never returns to idle
    set_req(3, 8'($urandom));
    serve(2, 0, 0);
    set_req(0, 8'($urandom));
    nb = 0;
    ng = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (!busy) nb++;
      if (|gnt) ng++;
    end
    chk("drain_busy", nb, 0);
    chk("drain_gnt", ng, 0);
    mm_en = 1;
    rx_next = 8'($urandom);
    serve(0, 0, 0);
    // async reset in the middle of a transfer
    timeout_limit = 0;
    mm_en = 0;
    force_idle = 1;
    set_req(3, 8'($urandom));
    ew = exp_win(rq, p);
    oh = 4'b0001 << ew;
    got = 0;
    for (int c = 0; c < 50 && !got; c++) begin
      tick();
      got = |gnt;
    end
    chk("rgnt_seen", 32'(got), 1);
    chk("rgnt", gnt, oh);
    rq[ew] = 1'b0;
    req = rq;
    tick();
    force_idle = 0;
    repeat (4) tick();
    chk("cs_wait_done", cs_n, 4'b0111);
    #2;
    rst = 1;
    #1;
    chk("arst_cs_n", cs_n, 4'hF);
    chk("arst_latch", m_latch, 0);
    chk("arst_gnt", gnt, 0);
    chk("arst_busy", busy, 1);
    tick();
    rst = 0;
    reset_model();
    set_req(0, 8'($urandom));
    ng = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (|gnt) ng++;
    end
    chk("post_rst_gnt", ng, 0);
    mm_en = 1;
    rx_next = 8'($urandom);
    serve(0, 0, 0);
    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      timeout_limit = $urandom_range(0, 1) == 1 ? 16'd200 : 16'd0;
      if (rq == 0) set_req($urandom_range(0, 3), 8'($urandom));
      if ($urandom_range(0, 3) == 0) cfg_write($urandom_range(0, 3), 16'($urandom_range(2, 60)), 2'($urandom));
      rx_next = 8'($urandom);
      serve(0, $urandom_range(0, 3) == 0, 1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
